// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// ALU/PC mux selects and the packed control word.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iOrD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memToReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic       ne;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
  } ctrl_t;

endpackage

// File: rtl/mc_opdecode.sv
// Combinational opcode classifier feeding the DECODE/MEMADR/BRANCH decisions.
module mc_opdecode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       isMem,
  output logic       isLoad,
  output logic       isRtype,
  output logic       isBranch,
  output logic       isBne,
  output logic       isAddi,
  output logic       isJump,
  output logic       isIllegal
);

  always_comb begin
    isMem     = 1'b0;
    isLoad    = 1'b0;
    isRtype   = 1'b0;
    isBranch  = 1'b0;
    isBne     = 1'b0;
    isAddi    = 1'b0;
    isJump    = 1'b0;
    isIllegal = 1'b0;
    case (opcode)
      OP_LW:    begin isMem = 1'b1; isLoad = 1'b1; end
      OP_SW:    isMem = 1'b1;
      OP_RTYPE: isRtype = 1'b1;
      OP_BEQ:   isBranch = 1'b1;
      OP_BNE:   begin isBranch = 1'b1; isBne = 1'b1; end
      OP_ADDI:  isAddi = 1'b1;
      OP_J:     isJump = 1'b1;
      default:  isIllegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: Moore control decode, memory-ready stalls and a
// retired-instruction counter.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int USE_MEM_READY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemToReg,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic        Ne,
  output logic        pc_en,
  output logic        illegal_op,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSource,
  output logic [3:0]  state,
  output logic [15:0] retired_count
);

  state_e      stateQ, stateNext;
  ctrl_t       ctrl;
  logic        illegal, retire, memRdy;
  logic [15:0] retiredCount;
  logic        isMem, isLoad, isRtype, isBranch, isBne, isAddi, isJump, isIllegal;

  assign memRdy = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

  mc_opdecode uDec (
    .opcode    (opcode),
    .isMem     (isMem),
    .isLoad    (isLoad),
    .isRtype   (isRtype),
    .isBranch  (isBranch),
    .isBne     (isBne),
    .isAddi    (isAddi),
    .isJump    (isJump),
    .isIllegal (isIllegal)
  );

  // Counter only writes on retire so a held value is never overwritten idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stateQ       <= S_FETCH;
      retiredCount <= 16'd0;
    end else begin
      stateQ <= stateNext;
      if (retire) retiredCount <= retiredCount + 16'd1;
    end
  end

  always_comb begin
    ctrl      = '0;
    stateNext = stateQ;
    illegal   = 1'b0;
    retire    = 1'b0;
    case (stateQ)
      S_FETCH: begin
        ctrl.memRead = 1'b1;
        ctrl.aluSrcB = SRCB_FOUR;
        ctrl.irWrite = memRdy;
        ctrl.pcWrite = memRdy;
        if (memRdy) stateNext = S_DECODE;
      end
      S_DECODE: begin
        ctrl.aluSrcB = SRCB_IMMSH;
        if (isMem)         stateNext = S_MEMADR;
        else if (isRtype)  stateNext = S_EXEC;
        else if (isBranch) stateNext = S_BRANCH;
        else if (isAddi)   stateNext = S_ADDIEX;
        else if (isJump)   stateNext = S_JUMP;
        else begin
          stateNext = S_FETCH;
          illegal   = isIllegal;
        end
      end
      S_MEMADR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        stateNext    = isLoad ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctrl.memRead = 1'b1;
        ctrl.iOrD    = 1'b1;
        if (memRdy) stateNext = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.memToReg = 1'b1;
        ctrl.regWrite = 1'b1;
        stateNext     = S_FETCH;
        retire        = 1'b1;
      end
      S_MEMWR: begin
        ctrl.memWrite = 1'b1;
        ctrl.iOrD     = 1'b1;
        if (memRdy) begin
          stateNext = S_FETCH;
          retire    = 1'b1;
        end
      end
      S_EXEC: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_REG;
        ctrl.aluOp   = ALU_FUNCT;
        stateNext    = S_RWB;
      end
      S_RWB: begin
        ctrl.regDst   = 1'b1;
        ctrl.regWrite = 1'b1;
        stateNext     = S_FETCH;
        retire        = 1'b1;
      end
      S_BRANCH: begin
        ctrl.aluSrcA     = 1'b1;
        ctrl.aluSrcB     = SRCB_REG;
        ctrl.aluOp       = ALU_SUB;
        ctrl.pcWriteCond = 1'b1;
        ctrl.pcSource    = PCS_ALUOUT;
        ctrl.ne          = isBne;
        stateNext        = S_FETCH;
        retire           = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALU_ADD;
        stateNext    = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctrl.regWrite = 1'b1;
        stateNext     = S_FETCH;
        retire        = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcWrite  = 1'b1;
        ctrl.pcSource = PCS_JUMP;
        stateNext     = S_FETCH;
        retire        = 1'b1;
      end
      default: stateNext = S_FETCH;
    endcase
    // Held in reset: strobes off, muxes parked at their FETCH settings.
    if (!reset) begin
      ctrl         = '0;
      ctrl.aluSrcB = SRCB_FOUR;
      illegal      = 1'b0;
    end
  end

  assign PCWrite       = ctrl.pcWrite;
  assign PCWriteCond   = ctrl.pcWriteCond;
  assign IorD          = ctrl.iOrD;
  assign MemRead       = ctrl.memRead;
  assign MemWrite      = ctrl.memWrite;
  assign IRWrite       = ctrl.irWrite;
  assign MemToReg      = ctrl.memToReg;
  assign RegDst        = ctrl.regDst;
  assign RegWrite      = ctrl.regWrite;
  assign ALUSrcA       = ctrl.aluSrcA;
  assign Ne            = ctrl.ne;
  assign ALUSrcB       = ctrl.aluSrcB;
  assign ALUOp         = ctrl.aluOp;
  assign PCSource      = ctrl.pcSource;
  assign pc_en         = ctrl.pcWrite | (ctrl.pcWriteCond & (zero ^ ctrl.ne));
  assign illegal_op    = illegal;
  assign state         = reset ? stateQ : S_FETCH;
  assign retired_count = retiredCount;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction table driven through a per-cycle
// scoreboard, plus hand sequences for stalls, reset mid-access and wrap.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset, zero, mem_ready;
  logic [5:0]  opcode;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg;
  logic        RegDst, RegWrite, ALUSrcA, Ne, pc_en, illegal_op;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [3:0]  state;
  logic [15:0] retired_count;

  multicycle_control #(.USE_MEM_READY(1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .Ne(Ne), .pc_en(pc_en),
    .illegal_op(illegal_op), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .state(state), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  // seq holds one expected state per cycle, cycle 0 in the low nibble;
  // rw/pc/ill masks give expected RegWrite/pc_en/illegal_op per cycle.
  typedef struct packed {
    logic [5:0]  op;
    logic        zero;
    logic [3:0]  len;
    logic [23:0] seq;
    logic [5:0]  rw;
    logic [5:0]  pc;
    logic [5:0]  ill;
    logic [1:0]  dRet;
  } vec_t;

  typedef struct packed {
    logic [3:0] st;
    logic       rw;
    logic       pc;
    logic       ill;
  } exp_t;

  exp_t        sb[$];
  int          nVec = 0;
  int          nFail = 0;
  logic [15:0] cntModel = 16'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyVec(input vec_t v);
    exp_t e;
    opcode = v.op;
    zero   = v.zero;
    for (int c = 0; c < int'(v.len); c++) begin
      e.st  = v.seq[4*c +: 4];
      e.rw  = v.rw[c];
      e.pc  = v.pc[c];
      e.ill = v.ill[c];
      sb.push_back(e);
    end
    for (int c = 0; c < int'(v.len); c++) begin
      e = sb.pop_front();
      chk($sformatf("op%02h c%0d state", v.op, c), 32'(state), 32'(e.st));
      chk($sformatf("op%02h c%0d RegWrite", v.op, c), 32'(RegWrite), 32'(e.rw));
      chk($sformatf("op%02h c%0d pc_en", v.op, c), 32'(pc_en), 32'(e.pc));
      chk($sformatf("op%02h c%0d illegal_op", v.op, c), 32'(illegal_op), 32'(e.ill));
      tick();
    end
    cntModel = cntModel + 16'(v.dRet);
    chk($sformatf("op%02h end state", v.op), 32'(state), 32'd0);
    chk($sformatf("op%02h retired_count", v.op), 32'(retired_count), 32'(cntModel));
  endtask

  vec_t vecs[12];
  vec_t jv;
  logic [3:0] lwSt[7];
  logic       lwMr[7];

  initial begin
    //              op         z     len    seq         rw         pc         ill        dRet
    vecs[0]  = '{6'b000000, 1'b0, 4'd4, 24'h007610, 6'b001000, 6'b000001, 6'b000000, 2'd1};
    vecs[1]  = '{6'b100011, 1'b0, 4'd5, 24'h043210, 6'b010000, 6'b000001, 6'b000000, 2'd1};
    vecs[2]  = '{6'b101011, 1'b1, 4'd4, 24'h005210, 6'b000000, 6'b000001, 6'b000000, 2'd1};
    vecs[3]  = '{6'b000100, 1'b1, 4'd3, 24'h000810, 6'b000000, 6'b000101, 6'b000000, 2'd1};
    vecs[4]  = '{6'b000100, 1'b0, 4'd3, 24'h000810, 6'b000000, 6'b000001, 6'b000000, 2'd1};
    vecs[5]  = '{6'b000101, 1'b1, 4'd3, 24'h000810, 6'b000000, 6'b000001, 6'b000000, 2'd1};
    vecs[6]  = '{6'b000101, 1'b0, 4'd3, 24'h000810, 6'b000000, 6'b000101, 6'b000000, 2'd1};
    vecs[7]  = '{6'b001000, 1'b0, 4'd4, 24'h00A910, 6'b001000, 6'b000001, 6'b000000, 2'd1};
    vecs[8]  = '{6'b000010, 1'b0, 4'd3, 24'h000B10, 6'b000000, 6'b000101, 6'b000000, 2'd1};
    vecs[9]  = '{6'b111111, 1'b0, 4'd2, 24'h000010, 6'b000000, 6'b000001, 6'b000010, 2'd0};
    vecs[10] = '{6'b000001, 1'b1, 4'd2, 24'h000010, 6'b000000, 6'b000001, 6'b000010, 2'd0};
    vecs[11] = '{6'b000000, 1'b1, 4'd4, 24'h007610, 6'b001000, 6'b000001, 6'b000000, 2'd1};
    jv       = '{6'b000010, 1'b0, 4'd3, 24'h000B10, 6'b000000, 6'b000101, 6'b000000, 2'd1};
    lwSt = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
    lwMr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    reset = 1'b0; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    chk("rst state", 32'(state), 32'd0);
    chk("rst MemRead", 32'(MemRead), 32'd0);
    chk("rst IRWrite", 32'(IRWrite), 32'd0);
    chk("rst PCWrite", 32'(PCWrite), 32'd0);
    chk("rst pc_en", 32'(pc_en), 32'd0);
    chk("rst ALUSrcB", 32'(ALUSrcB), 32'd1);
    chk("rst retired_count", 32'(retired_count), 32'd0);

    // First cycle out of reset is already a fetch.
    reset = 1'b1;
    #1;
    chk("first fetch MemRead", 32'(MemRead), 32'd1);
    chk("first fetch IRWrite", 32'(IRWrite), 32'd1);

    foreach (vecs[i]) applyVec(vecs[i]);

    // Fetch stall holds FETCH with IR/PC writes off.
    mem_ready = 1'b0;
    #1;
    chk("fetch stall IRWrite", 32'(IRWrite), 32'd0);
    chk("fetch stall PCWrite", 32'(PCWrite), 32'd0);
    tick();
    chk("fetch stall state", 32'(state), 32'd0);
    mem_ready = 1'b1;

    // lw with two not-ready cycles in MEMRD: seven cycles total.
    opcode = 6'b100011;
    for (int i = 0; i < 7; i++) begin
      mem_ready = lwMr[i];
      #1;
      chk($sformatf("lw stall c%0d state", i), 32'(state), 32'(lwSt[i]));
      if (i == 6) chk("lw stall MemToReg", 32'(MemToReg), 32'd1);
      tick();
    end
    cntModel++;
    chk("lw stall end state", 32'(state), 32'd0);
    chk("lw stall retired_count", 32'(retired_count), 32'(cntModel));

    // bne taken-not-taken detail in BRANCH.
    opcode = 6'b000101; zero = 1'b1;
    tick(); tick();
    chk("bne Ne", 32'(Ne), 32'd1);
    chk("bne PCWriteCond", 32'(PCWriteCond), 32'd1);
    chk("bne PCSource", 32'(PCSource), 32'd1);
    chk("bne pc_en", 32'(pc_en), 32'd0);
    tick();
    cntModel++;

    // Reset while MEMWR is waiting on memory.
    opcode = 6'b101011;
    tick(); tick();
    mem_ready = 1'b0;
    tick();
    chk("sw wait state", 32'(state), 32'd5);
    chk("sw wait MemWrite", 32'(MemWrite), 32'd1);
    tick();
    chk("sw wait held", 32'(state), 32'd5);
    reset = 1'b0;
    #1;
    chk("sw rst MemWrite", 32'(MemWrite), 32'd0);
    chk("sw rst state out", 32'(state), 32'd0);
    tick();
    reset = 1'b1; mem_ready = 1'b1;
    #1;
    cntModel = 16'd0;
    chk("sw rst state", 32'(state), 32'd0);
    chk("sw rst retired_count", 32'(retired_count), 32'(cntModel));

    // Wrap: preload near the top, then retire jumps across FFFF.
    force dut.retiredCount = 16'hFFFD;
    #1;
    release dut.retiredCount;
    cntModel = 16'hFFFD;
    for (int i = 0; i < 3; i++) applyVec(jv);
    chk("wrap final", 32'(retired_count), 32'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter USE_MEM_READY, default 1; when 0, mem_ready is ignored and treated as 1.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-low; reset==0 at a rising edge resets the block.
REQ-004 opcode  input  6  instruction[31:26] from the datapath IR; stable outside FETCH.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory handshake; access completes in the cycle it is 1.
REQ-007 Outputs, 1 bit each: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA, Ne, pc_en, illegal_op.
REQ-008 Outputs ALUSrcB, ALUOp and PCSource are 2 bits each; state is a 4-bit output for debug; retired_count is a 16-bit output.

Function
REQ-009 Control outputs SHALL be Moore, decoded from state only; signals not listed for a state are 0.
REQ-010 pc_en SHALL equal PCWrite | (PCWriteCond & (zero ^ Ne)).
REQ-011 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=mem_ready; goes to DECODE on mem_ready, else holds.
REQ-012 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next state by opcode as listed in REQ-012a to REQ-012d.
REQ-012a Opcodes 100011 and 101011 go to MEMADR.
REQ-012b Opcode 000000 goes to EXEC; opcodes 000100 and 000101 go to BRANCH.
REQ-012c Opcode 001000 goes to ADDIEX; opcode 000010 goes to JUMP.
REQ-012d Any other opcode goes to FETCH, with illegal_op=1 for that DECODE cycle.
REQ-013 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; goes to MEMRD for opcode 100011, else MEMWR.
REQ-014 MEMRD: MemRead=1, IorD=1; goes to MEMWB on mem_ready, else holds.
REQ-015 MEMWB: RegDst=0, MemToReg=1, RegWrite=1; next state FETCH.
REQ-016 MEMWR: MemWrite=1, IorD=1; goes to FETCH on mem_ready, else holds.
REQ-017 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next state RWB.
REQ-018 RWB: RegDst=1, MemToReg=0, RegWrite=1; next state FETCH.
REQ-019 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, Ne=(opcode==000101); next state FETCH.
REQ-020 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state ADDIWB.
REQ-021 ADDIWB: RegDst=0, MemToReg=0, RegWrite=1; next state FETCH.
REQ-022 JUMP: PCWrite=1, PCSource=10; next state FETCH.
REQ-023 Latency with mem_ready=1 (FETCH to FETCH): beq/bne/j 3 cycles; R-type, addi and sw 4 cycles; lw 5 cycles; each mem_ready=0 cycle adds one.
REQ-024 retired_count SHALL increment by 1 on each exit from MEMWB, RWB, BRANCH, ADDIWB or JUMP, and on the MEMWR cycle with mem_ready=1; it wraps FFFF->0000.
REQ-025 Illegal opcodes and illegal-state entry SHALL NOT increment retired_count.
REQ-026 Unused state encodings SHALL go to FETCH on the next edge with all control outputs 0.

Reset
REQ-027 On a clk edge with reset==0: state=FETCH and retired_count=0, regardless of current state or a pending mem_ready wait.
REQ-028 While reset==0, PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite, pc_en and illegal_op SHALL be forced 0 combinationally.
REQ-029 While reset==0, all other outputs SHALL take their FETCH values.
REQ-030 The first instruction fetch SHALL begin in the first cycle with reset==1.

Structure
REQ-031 Shared package mips_pkg SHALL hold: state encodings, opcode constants (RTYPE, LW, SW, BEQ, BNE, ADDI, J), ALUOp codes (00 add, 01 sub, 10 funct) and PCSource codes.
REQ-032 Opcode classification SHALL be one combinational sub-module, mc_opdecode; state register, next-state logic, output decode and counter stay in multicycle_control.

Verification
REQ-033 Reset then opcode=000000, mem_ready=1 -> states FETCH,DECODE,EXEC,RWB,FETCH; RegWrite=1 and RegDst=1 only in RWB; retired_count=1.
REQ-034 lw with mem_ready low for 2 cycles in MEMRD -> MEMRD held for 3 cycles; MEMWB follows; total 7 cycles; MemToReg=1 in MEMWB.
REQ-035 beq zero=1 -> pc_en=1 in BRANCH; bne zero=1 -> Ne=1, pc_en=0.
REQ-036 opcode=111111 in DECODE -> illegal_op=1 for one cycle, FETCH next, retired_count unchanged.
REQ-037 reset=0 asserted in MEMWR mid-wait -> FETCH next edge; MemWrite=0 during reset; retired_count=0.
REQ-038 Preload via 65536 j instructions -> retired_count wraps to 0000.
